// File: rtl/tri_s_bank_if.sv
// Control bundle for tri_s_bank: register write commands, read select and
// drive request from the master, bus-drive status back from the bank.
interface tri_s_bank_if #(
    parameter int unsigned reg_size = 8,
    parameter int unsigned depth    = 4
);
    localparam int unsigned SelW = $clog2(depth);

    logic [reg_size-1:0] X;
    logic [SelW-1:0]     WR_SEL;
    logic [1:0]          MODE;
    logic                SIN;
    logic [SelW-1:0]     RD_SEL;
    logic                ENABLE;
    logic                DRIVING;

    modport master (
        output X, WR_SEL, MODE, SIN, RD_SEL, ENABLE,
        input  DRIVING
    );

    modport slave (
        input  X, WR_SEL, MODE, SIN, RD_SEL, ENABLE,
        output DRIVING
    );
endinterface

// File: rtl/tri_s_bank.sv
// Register bank with per-register load/shift/increment and a registered,
// three-state read port that can insert one idle turnaround cycle when the
// read select changes while the bus is being driven.
module tri_s_bank #(
    parameter int unsigned reg_size   = 8,
    parameter int unsigned depth      = 4,
    parameter int unsigned turnaround = 1
) (
    input  logic                CLOCK,
    input  logic                CLEAR,
    tri_s_bank_if.slave         bus,
    output tri [reg_size-1:0]   Y
);
    localparam int unsigned SelW = $clog2(depth);

    typedef enum logic [1:0] {
        ModeHold  = 2'b00,
        ModeLoad  = 2'b01,
        ModeShift = 2'b10,
        ModeInc   = 2'b11
    } mode_e;

    logic [reg_size-1:0] regs_q [depth];
    logic [reg_size-1:0] regs_d [depth];
    logic [reg_size-1:0] out_q, out_d;
    logic                drive_q, drive_d;
    logic [SelW-1:0]     prev_sel_q;
    logic                gap;

    // Next-state for the addressed register and the read-before-write mux.
    // Selects are compared per index so out-of-range selects match nothing.
    always_comb begin
        regs_d = regs_q;
        out_d  = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            if (bus.WR_SEL == SelW'(i)) begin
                unique case (mode_e'(bus.MODE))
                    ModeHold:  regs_d[i] = regs_q[i];
                    ModeLoad:  regs_d[i] = bus.X;
                    ModeShift: regs_d[i] = {bus.SIN, regs_q[i][reg_size-1:1]};
                    ModeInc:   regs_d[i] = regs_q[i] + reg_size'(1);
                    default:   regs_d[i] = regs_q[i];
                endcase
            end
            if (bus.RD_SEL == SelW'(i)) begin
                out_d = regs_q[i];
            end
        end
    end

    // A select change while already driving costs one released cycle.
    always_comb begin
        gap     = (turnaround != 0) && bus.ENABLE && (bus.RD_SEL != prev_sel_q) && drive_q;
        drive_d = bus.ENABLE && !gap;
    end

    // All state, cleared asynchronously so the bus is released immediately.
    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            for (int unsigned i = 0; i < depth; i++) begin
                regs_q[i] <= '0;
            end
            out_q      <= '0;
            drive_q    <= 1'b0;
            prev_sel_q <= '0;
        end else begin
            regs_q     <= regs_d;
            out_q      <= out_d;
            drive_q    <= drive_d;
            prev_sel_q <= bus.RD_SEL;
        end
    end

    assign Y           = drive_q ? out_q : {reg_size{1'bz}};
    assign bus.DRIVING = drive_q;
endmodule

// File: tb/tb_tri_s_bank.sv
// Directed bench for tri_s_bank: a vector table for single-cycle behaviour
// and hand sequences for turnaround and asynchronous clear.
module tb_tri_s_bank;
    localparam int unsigned W = 8;
    localparam int unsigned D = 6;

    logic         clk;
    logic         clear;
    wire  [W-1:0] y_a;
    wire  [W-1:0] y_b;
    int           total;
    int           bad;

    tri_s_bank_if #(.reg_size(W), .depth(D)) bus_a ();
    tri_s_bank_if #(.reg_size(W), .depth(D)) bus_b ();

    assign bus_b.X      = bus_a.X;
    assign bus_b.WR_SEL = bus_a.WR_SEL;
    assign bus_b.MODE   = bus_a.MODE;
    assign bus_b.SIN    = bus_a.SIN;
    assign bus_b.RD_SEL = bus_a.RD_SEL;
    assign bus_b.ENABLE = bus_a.ENABLE;

    tri_s_bank #(.reg_size(W), .depth(D), .turnaround(1)) dut_a (
        .CLOCK (clk),
        .CLEAR (clear),
        .bus   (bus_a.slave),
        .Y     (y_a)
    );

    tri_s_bank #(.reg_size(W), .depth(D), .turnaround(0)) dut_b (
        .CLOCK (clk),
        .CLEAR (clear),
        .bus   (bus_b.slave),
        .Y     (y_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]   mode;
        logic [2:0]   wr;
        logic [W-1:0] x;
        logic         sin;
        logic [2:0]   rd;
        logic         en;
        logic         drv;
        logic [W-1:0] y;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic [1:0] mode, logic [2:0] wr, logic [W-1:0] x, logic sin,
                               logic [2:0] rd, logic en, logic drv, logic [W-1:0] y);
        vec_t r;
        r.mode = mode; r.wr = wr; r.x = x; r.sin = sin;
        r.rd = rd; r.en = en; r.drv = drv; r.y = y;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic [2:0] wr, input logic [W-1:0] x,
                         input logic sin, input logic [2:0] rd, input logic en);
        bus_a.MODE   = mode;
        bus_a.WR_SEL = wr;
        bus_a.X      = x;
        bus_a.SIN    = sin;
        bus_a.RD_SEL = rd;
        bus_a.ENABLE = en;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 3'd0, '0, 1'b0, 3'd0, 1'b0);
        clear = 1'b0;
        step();
        #2 clear = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear = 1'b0;
        drive(2'b00, 3'd0, '0, 1'b0, 3'd0, 1'b0);
        #12;
        chk("reset_drv_a", {31'd0, bus_a.DRIVING}, 32'd0);
        chk("reset_drv_b", {31'd0, bus_b.DRIVING}, 32'd0);
        clear = 1'b1;

        //       mode   wr    x      sin   rd    en    drv   y
        tbl.push_back(v(2'b01, 3'd2, 8'd100, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd2, 1'b1, 1'b1, 8'd100));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd2, 1'b1, 1'b1, 8'd100));
        tbl.push_back(v(2'b01, 3'd1, 8'hFF, 1'b0, 3'd2, 1'b1, 1'b1, 8'd100));
        tbl.push_back(v(2'b11, 3'd1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(2'b01, 3'd0, 8'h81, 1'b0, 3'd2, 1'b0, 1'b0, 8'h00));
        tbl.push_back(v(2'b10, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(v(2'b10, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b1, 8'hC0));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 8'hE0));
        tbl.push_back(v(2'b01, 3'd2, 8'h03, 1'b0, 3'd2, 1'b0, 1'b0, 8'h00));
        tbl.push_back(v(2'b01, 3'd2, 8'h07, 1'b0, 3'd2, 1'b1, 1'b1, 8'h03));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd2, 1'b1, 1'b1, 8'h07));
        tbl.push_back(v(2'b01, 3'd6, 8'h55, 1'b0, 3'd2, 1'b1, 1'b1, 8'h07));
        tbl.push_back(v(2'b01, 3'd7, 8'hAA, 1'b0, 3'd2, 1'b1, 1'b1, 8'h07));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd6, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd6, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 8'hE0));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd5, 1'b1, 1'b0, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00));
        tbl.push_back(v(2'b00, 3'd0, 8'h00, 1'b0, 3'd5, 1'b0, 1'b0, 8'h00));

        foreach (tbl[i]) begin
            drive(tbl[i].mode, tbl[i].wr, tbl[i].x, tbl[i].sin, tbl[i].rd, tbl[i].en);
            step();
            chk($sformatf("vec%0d_drv", i), {31'd0, bus_a.DRIVING}, {31'd0, tbl[i].drv});
            if (tbl[i].drv) begin
                chk($sformatf("vec%0d_y", i), {24'd0, y_a}, {24'd0, tbl[i].y});
            end
        end

        // Turnaround versus direct switch: R0=5, R3=9.
        do_reset();
        drive(2'b01, 3'd0, 8'd5, 1'b0, 3'd0, 1'b0);
        step();
        drive(2'b01, 3'd3, 8'd9, 1'b0, 3'd0, 1'b1);
        step();
        chk("ta_start_y_a", {24'd0, y_a}, 32'd5);
        chk("ta_start_y_b", {24'd0, y_b}, 32'd5);
        drive(2'b00, 3'd0, 8'd0, 1'b0, 3'd3, 1'b1);
        step();
        chk("ta_gap_drv_a", {31'd0, bus_a.DRIVING}, 32'd0);
        chk("ta_nogap_drv_b", {31'd0, bus_b.DRIVING}, 32'd1);
        chk("ta_nogap_y_b", {24'd0, y_b}, 32'd9);
        step();
        chk("ta_after_drv_a", {31'd0, bus_a.DRIVING}, 32'd1);
        chk("ta_after_y_a", {24'd0, y_a}, 32'd9);

        // Asynchronous clear between edges while driving.
        #2 clear = 1'b0;
        #1;
        chk("aclr_drv_a", {31'd0, bus_a.DRIVING}, 32'd0);
        chk("aclr_drv_b", {31'd0, bus_b.DRIVING}, 32'd0);
        // Inputs during clear are ignored, including across a clock edge.
        drive(2'b01, 3'd3, 8'hAA, 1'b0, 3'd3, 1'b1);
        step();
        chk("aclr_held_drv_a", {31'd0, bus_a.DRIVING}, 32'd0);
        drive(2'b00, 3'd0, 8'h00, 1'b0, 3'd3, 1'b1);
        #2 clear = 1'b1;
        step();
        chk("post_clr_drv_a", {31'd0, bus_a.DRIVING}, 32'd1);
        chk("post_clr_r3_a", {24'd0, y_a}, 32'd0);
        chk("post_clr_r3_b", {24'd0, y_b}, 32'd0);
        drive(2'b00, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
        step();
        chk("post_clr_r0_b", {24'd0, y_b}, 32'd0);
        step();
        chk("post_clr_r0_a", {24'd0, y_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tri_s_bank.md
TRI_S_BANK -- requirements
Module: tri_s_bank

Interface
REQ-001 SHALL provide parameter reg_size, default 8, meaning the data width of each register and of the bus.
REQ-002 SHALL provide parameter depth, default 4, meaning the number of registers; legal values are 2..16.
REQ-003 SHALL provide parameter turnaround, default 1, meaning a bus-turnaround idle cycle is inserted on a read-select change (1) or not (0).
REQ-004 CLOCK  input  1  sole clock; rising edge active.
REQ-005 CLEAR  input  1  reset; asynchronous, active-low.
REQ-006 X  input  reg_size  parallel load data.
REQ-007 WR_SEL  input  clog2(depth)  register targeted by MODE.
REQ-008 MODE  input  2  operation on the selected register: 00 hold, 01 load, 10 shift-right, 11 increment.
REQ-009 SIN  input  1  serial-in bit for shift-right.
REQ-010 RD_SEL  input  clog2(depth)  register presented on the bus.
REQ-011 ENABLE  input  1  bus drive request.
REQ-012 Y  output (tri)  reg_size  shared three-state bus.
REQ-013 DRIVING  output  1  high exactly when Y is actively driven.

Function
REQ-014 SHALL hold depth registers R[0..depth-1] of reg_size bits each.
REQ-015 On a rising CLOCK edge, only R[WR_SEL] SHALL be updated per MODE; all other registers hold.
REQ-016 MODE 01 SHALL set R[WR_SEL] <= X.
REQ-017 MODE 10 SHALL set R[WR_SEL] <= {SIN, R[WR_SEL][reg_size-1:1]}; the LSB is discarded.
REQ-018 MODE 11 SHALL set R[WR_SEL] <= R[WR_SEL]+1 modulo 2^reg_size; all-ones wraps to 0.
REQ-019 When WR_SEL >= depth, no register SHALL change, regardless of MODE.
REQ-020 Each rising edge SHALL capture the output stage: out_q <= R[RD_SEL] as it was before that edge's write (read-before-write), or 0 when RD_SEL >= depth.
REQ-021 Each rising edge SHALL set drive_q <= ENABLE and not(gap), where gap = turnaround and ENABLE and (RD_SEL != prev_sel) and drive_q.
REQ-022 prev_sel SHALL capture RD_SEL on every rising edge.
REQ-023 Y SHALL equal out_q when drive_q is 1 and all-Z otherwise; DRIVING SHALL equal drive_q.
REQ-024 Read latency SHALL be one cycle from ENABLE/RD_SEL sampled to Y driven; drive release SHALL also take one cycle.
REQ-025 With turnaround=1, a RD_SEL change while driving SHALL produce exactly one Z cycle, after which the new register is driven; with turnaround=0, Y SHALL switch directly.
REQ-026 A RD_SEL change while not driving SHALL NOT insert a gap.
REQ-027 Simultaneous write and read of the same register SHALL present the old value on the following cycle and the new value one cycle later.

Reset
REQ-028 CLEAR low SHALL immediately, without a clock edge, force all R[i] = 0, out_q = 0, drive_q = 0, and prev_sel = 0; Y SHALL be all-Z and DRIVING 0.
REQ-029 While CLEAR is low, all inputs SHALL be ignored; the first active edge SHALL be the first rising CLOCK edge after CLEAR goes high.
REQ-030 Assertion of CLEAR mid-operation, including during a turnaround gap or a drive, SHALL release the bus within the same time step.

Verification
REQ-031 Reset, then MODE=01, WR_SEL=2, X=100; then RD_SEL=2, ENABLE=1 -> Y is Z for the first enabled edge, and Y=100 with DRIVING=1 from the next edge.
REQ-032 R[1]=8'hFF, MODE=11, WR_SEL=1, one edge -> R[1]=0; read -> Y=0; other registers unchanged.
REQ-033 R[0]=8'h81, MODE=10, SIN=1, two edges -> R[0]=8'hE0.
REQ-034 Driving R[0]=5, RD_SEL switched to 3 (R[3]=9), turnaround=1 -> one Z cycle with DRIVING=0, then Y=9; with turnaround=0, Y goes 5 then 9 with no gap.
REQ-035 Same edge: load R[2]=7 (old value 3) and read RD_SEL=2 -> Y=3, then Y=7; WR_SEL>=depth with MODE=01 -> no register changes.
REQ-036 CLEAR low asynchronously mid-drive (between edges) -> Y=Z and DRIVING=0 at once; after release, all reads return 0.
